// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: drives an iterative AES core in counter mode and streams
// the resulting blocks out through a 2-entry first-word-fall-through buffer.
module aes_ctr_sequencer #(
  parameter int CNT_W   = 24,
  parameter int NONCE_W = 64
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [127:0]       key_in,
  input  logic               key_load,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CNT_W-1:0]   n_blocks,
  input  logic               start,
  input  logic               abort,
  output logic [127:0]       rnd_out,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               busy,
  output logic               done,
  output logic               key_ok,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic [127:0]       aes_kin,
  output logic [127:0]       aes_din,
  output logic               aes_krdy,
  output logic               aes_drdy,
  output logic               aes_en,
  input  logic [127:0]       aes_dout,
  input  logic               aes_kvld,
  input  logic               aes_dvld,
  input  logic               aes_bsy
);
  localparam int IDX_W = 128 - NONCE_W;
  typedef enum logic [2:0] {IDLE, KEY, ISSUE, WAIT, DRAIN, FIN} state_t;
  state_t state, state_nx;
  logic [NONCE_W-1:0] nonce_r;
  logic [CNT_W-1:0] nblk_r;
  logic [IDX_W-1:0] idx;
  logic abort_pend;
  logic [127:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  logic do_key, do_start, do_issue, do_push, flush, pop;
  assign aes_en = 1'b1;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign rnd_valid = cnt != 2'd0;
  assign rnd_out = mem[rp];
  assign pop = rnd_valid && rnd_ready;
  always_comb begin
    state_nx = state;
    do_key = 1'b0;
    do_start = 1'b0;
    do_issue = 1'b0;
    do_push = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: begin
        do_key = key_load;
        do_start = !key_load && start && key_ok;
        state_nx = key_load ? KEY : do_start ? ISSUE : IDLE;
      end
      KEY: state_nx = aes_kvld ? IDLE : KEY;
      ISSUE: begin
        flush = abort;
        do_issue = !abort && blk_cnt != nblk_r && cnt != 2'd2 && !aes_bsy;
        state_nx = abort ? FIN : blk_cnt == nblk_r ? DRAIN : do_issue ? WAIT : ISSUE;
      end
      // A pending abort discards the in-flight block instead of buffering it
      WAIT: begin
        flush = aes_dvld && (abort || abort_pend);
        do_push = aes_dvld && !flush;
        state_nx = flush ? FIN : aes_dvld ? ISSUE : WAIT;
      end
      DRAIN: begin
        flush = abort;
        state_nx = (abort || !rnd_valid) ? FIN : DRAIN;
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      key_ok <= 1'b0;
      aes_krdy <= 1'b0;
      aes_drdy <= 1'b0;
      aes_kin <= '0;
      aes_din <= '0;
      nonce_r <= '0;
      nblk_r <= '0;
      idx <= '0;
      blk_cnt <= '0;
      abort_pend <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      state <= state_nx;
      aes_krdy <= do_key;
      aes_drdy <= do_issue;
      if (do_key) aes_kin <= key_in;
      if (state == KEY && aes_kvld) key_ok <= 1'b1;
      if (do_start) begin
        nonce_r <= nonce;
        nblk_r <= n_blocks;
        idx <= '0;
        blk_cnt <= '0;
      end
      if (do_issue) begin
        aes_din <= {nonce_r, idx};
        idx <= idx + IDX_W'(1);
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
      abort_pend <= state == WAIT && !aes_dvld && (abort || abort_pend);
      if (do_push) mem[wp] <= aes_dout;
      wp <= flush ? 1'b0 : wp ^ do_push;
      rp <= flush ? 1'b0 : rp ^ pop;
      cnt <= flush ? 2'd0 : cnt + {1'b0, do_push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb_aes_ctr_sequencer: directed bench with a toy cipher core model and a
// block-stream scoreboard checked every cycle.
module tb_aes_ctr_sequencer;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic [127:0] key_in = '0;
  logic key_load = 1'b0, start = 1'b0, abort = 1'b0, rnd_ready = 1'b0;
  logic [63:0] nonce = '0;
  logic [23:0] n_blocks = '0;
  logic [127:0] rnd_out, aes_kin, aes_din;
  logic rnd_valid, busy, done, key_ok, aes_krdy, aes_drdy, aes_en;
  logic [23:0] blk_cnt;
  logic [127:0] dout_m = '0, kin_l = '0, din_l = '0, core_key = '0;
  logic kvld_m = 1'b0, dvld_m = 1'b0, bsy_m = 1'b0;
  int kt = 0, dt = 0;

  aes_ctr_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .key_load(key_load), .nonce(nonce),
    .n_blocks(n_blocks), .start(start), .abort(abort), .rnd_out(rnd_out),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .busy(busy), .done(done),
    .key_ok(key_ok), .blk_cnt(blk_cnt), .aes_kin(aes_kin), .aes_din(aes_din),
    .aes_krdy(aes_krdy), .aes_drdy(aes_drdy), .aes_en(aes_en), .aes_dout(dout_m),
    .aes_kvld(kvld_m), .aes_dvld(dvld_m), .aes_bsy(bsy_m)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in cipher: any fixed bijection of (key, block) serves for sequencing.
  function automatic logic [127:0] f(input logic [127:0] k, input logic [127:0] d);
    return ~(k + {d[63:0], d[127:64]});
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Core model: key ready 3 cycles after krdy, data 4 cycles after drdy.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      kt <= 0; dt <= 0; kvld_m <= 1'b0; dvld_m <= 1'b0; bsy_m <= 1'b0; dout_m <= '0;
    end else begin
      kvld_m <= 1'b0;
      dvld_m <= 1'b0;
      if (aes_krdy) begin
        kin_l <= aes_kin; kt <= 3;
      end else if (kt != 0) begin
        kt <= kt - 1;
        if (kt == 1) begin kvld_m <= 1'b1; core_key <= kin_l; end
      end
      if (aes_drdy) begin
        din_l <= aes_din; dt <= 4; bsy_m <= 1'b1;
      end else if (dt != 0) begin
        dt <= dt - 1;
        if (dt == 1) begin dvld_m <= 1'b1; bsy_m <= 1'b0; dout_m <= f(core_key, din_l); end
      end
    end
  end

  logic [127:0] exp_q[$], din_log[$], pop_log[$];
  logic [63:0] exp_nonce = '0, exp_idx = '0;
  int drdy_total = 0, krdy_total = 0, pop_total = 0, done_total = 0;
  int run_iss = 0, run_pop = 0, run_pop_at_done = 0, last_done_cyc = 0, start_cyc = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [127:0] prev_out = '0;

  always @(negedge CLK) begin
    if (!RSTn) pv <= 1'b0;
    else begin
      chk("aes_en", aes_en, 1);
      if (aes_krdy) krdy_total++;
      if (kt != 0) chk("kin_hold", aes_kin, kin_l);
      if (dt != 0) chk("din_hold", aes_din, din_l);
      if (aes_drdy) begin
        drdy_total++;
        run_iss++;
        din_log.push_back(aes_din);
        chk("din", aes_din, {exp_nonce, exp_idx});
        exp_idx++;
        chk("occupancy", 128'(run_iss - run_pop <= 2), 1);
      end
      if (pv && !pr && rnd_valid) chk("out_hold", rnd_out, prev_out);
      if (rnd_valid && rnd_ready) begin
        pop_total++;
        run_pop++;
        pop_log.push_back(rnd_out);
        if (exp_q.size() == 0) chk("unexpected_pop", rnd_out, ~rnd_out);
        else chk("rnd_out", rnd_out, exp_q.pop_front());
      end
      if (done) begin done_total++; last_done_cyc = cyc; run_pop_at_done = run_pop; end
      pv <= rnd_valid;
      pr <= rnd_ready;
      prev_out <= rnd_out;
    end
  end

  task automatic run_start(input logic [63:0] nn, input logic [23:0] nb, input bit expect_run);
    if (expect_run) begin
      exp_nonce = nn; exp_idx = '0; run_iss = 0; run_pop = 0;
      for (int i = 0; i < int'(nb); i++) exp_q.push_back(f(128'd123, {nn, 64'(i)}));
    end
    @(posedge CLK); #1;
    nonce = nn; n_blocks = nb; start = 1'b1; start_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_total;
    for (int i = 0; i < 1000 && done_total == d0; i++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1 chk(name, 128'(done_total - d0), 1);
  endtask

  task automatic wait_drdy(input int target);
    for (int i = 0; i < 500 && drdy_total < target; i++) @(posedge CLK);
  endtask

  int d, p, dl0, pl0;
  initial begin
    repeat (3) @(posedge CLK); #1;
    chk("rst_valid", rnd_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_key_ok", key_ok, 0); chk("rst_blk_cnt", blk_cnt, 0); chk("rst_krdy", aes_krdy, 0);
    chk("rst_drdy", aes_drdy, 0); chk("rst_kin", aes_kin, 0); chk("rst_din", aes_din, 0);
    chk("rst_out", rnd_out, 0); chk("rst_en", aes_en, 1);
    RSTn = 1'b1;
    d = drdy_total;
    run_start(64'd0, 24'd3, 0);
    repeat (8) @(posedge CLK); #1;
    chk("busy_nokey", busy, 0); chk("drdy_nokey", 128'(drdy_total - d), 0);
    d = krdy_total;
    @(posedge CLK); #1 key_in = 128'd123; key_load = 1'b1;
    @(posedge CLK); #1 key_load = 1'b0;
    chk("krdy", aes_krdy, 1); chk("kin", aes_kin, 128'd123); chk("busy_key", busy, 1);
    for (int i = 0; i < 100 && !key_ok; i++) @(posedge CLK);
    @(posedge CLK); #1;
    chk("key_ok", key_ok, 1); chk("busy_after_key", busy, 0); chk("krdy_once", 128'(krdy_total - d), 1);
    // plain run, consumer always ready
    rnd_ready = 1'b1; d = drdy_total; dl0 = din_log.size(); pl0 = pop_log.size();
    run_start(64'd0, 24'd3, 1);
    wait_done("done_run1");
    chk("blk_cnt_run1", blk_cnt, 3); chk("drdy_run1", 128'(drdy_total - d), 3);
    chk("left_run1", 128'(exp_q.size()), 0); chk("pops_before_done", 128'(run_pop_at_done), 3);
    chk("ndin_run1", 128'(din_log.size() - dl0), 3);
    chk("npop_run1", 128'(pop_log.size() - pl0), 3);
    if (din_log.size() >= dl0 + 3)
      for (int i = 0; i < 3; i++) chk("din_lit", din_log[dl0 + i], 128'(i));
    if (pop_log.size() >= pl0 + 3) begin
      chk("blk0_lit", pop_log[pl0], ~128'd123);
      chk("blk1_lit", pop_log[pl0 + 1], 128'hFFFFFFFFFFFFFFFE_FFFFFFFFFFFFFF84);
      chk("blk2_lit", pop_log[pl0 + 2], 128'hFFFFFFFFFFFFFFFD_FFFFFFFFFFFFFF84);
    end
    // backpressure until both buffer entries are full
    rnd_ready = 1'b0; d = drdy_total;
    run_start(64'd0, 24'd3, 1);
    wait_drdy(d + 2);
    repeat (20) @(posedge CLK); #1;
    chk("drdy_full", 128'(drdy_total - d), 2); chk("valid_full", rnd_valid, 1);
    chk("hold_first", rnd_out, ~128'd123); chk("busy_full", busy, 1);
    rnd_ready = 1'b1;
    wait_done("done_run2");
    chk("left_run2", 128'(exp_q.size()), 0); chk("drdy_run2", 128'(drdy_total - d), 3);
    // zero-length run
    d = drdy_total;
    run_start(64'd0, 24'd0, 1);
    wait_done("done_zero");
    chk("done_latency", 128'(last_done_cyc - start_cyc), 3); chk("drdy_zero", 128'(drdy_total - d), 0);
    // abort while block 3 is in flight
    d = drdy_total; p = pop_total;
    run_start(64'hA5, 24'd10, 1);
    wait_drdy(d + 4);
    #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    wait_done("done_abort");
    chk("pops_abort", 128'(pop_total - p), 3); chk("left_abort", 128'(exp_q.size()), 7);
    chk("valid_abort", rnd_valid, 0); chk("busy_abort", busy, 0); chk("drdy_abort", 128'(drdy_total - d), 4);
    exp_q.delete();
    dl0 = din_log.size();
    run_start(64'h5A, 24'd2, 1);
    wait_done("done_restart");
    chk("left_restart", 128'(exp_q.size()), 0);
    if (din_log.size() > dl0) chk("restart_idx0", din_log[dl0], {64'h5A, 64'd0});
    else chk("restart_issued", 128'(din_log.size() - dl0), 2);
    // reset in the middle of WAIT
    d = drdy_total;
    run_start(64'd0, 24'd5, 1);
    wait_drdy(d + 1);
    #1 RSTn = 1'b0;
    #1;
    chk("mid_key_ok", key_ok, 0); chk("mid_busy", busy, 0); chk("mid_valid", rnd_valid, 0);
    chk("mid_blk_cnt", blk_cnt, 0); chk("mid_drdy", aes_drdy, 0); chk("mid_din", aes_din, 0);
    chk("mid_done", done, 0);
    repeat (2) @(posedge CLK); #1 RSTn = 1'b1;
    exp_q.delete();
    d = drdy_total;
    run_start(64'd0, 24'd2, 0);
    repeat (8) @(posedge CLK); #1;
    chk("busy_after_rst", busy, 0); chk("key_ok_after_rst", key_ok, 0);
    chk("drdy_after_rst", 128'(drdy_total - d), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
- Drives one iterative AES_Composite_enc core in counter mode to produce a stream of 128-bit pseudorandom blocks for the correlated-randomness generator.
- Loads the key, issues counter blocks {nonce, index} one at a time and collects Dout into a 2-entry output buffer.
- Presents the buffered blocks on a valid/ready stream and reports completion.

Parameters:
- CNT_W, 24, width of the block-count request and the produced-block counter.
- NONCE_W, 64, nonce width; counter block = {nonce, idx}, idx width = 128-NONCE_W.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset, asynchronous, active-low.
- key_in  in  128  AES key.
- key_load  in  1  one-cycle request to load key_in into the core.
- nonce  in  NONCE_W  nonce, sampled on accepted start.
- n_blocks  in  CNT_W  number of blocks to produce, sampled on accepted start.
- start  in  1  one-cycle run request.
- abort  in  1  one-cycle abort request.
- rnd_out  out  128  output block.
- rnd_valid  out  1  rnd_out valid.
- rnd_ready  in  1  consumer ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run or abort.
- key_ok  out  1  a key has been loaded since reset.
- blk_cnt  out  CNT_W  blocks issued in the current run.
- aes_kin, aes_din  out  128  core Kin/Din.
- aes_krdy, aes_drdy  out  1  core Krdy/Drdy pulses.
- aes_en  out  1  core EN; tied 1.
- aes_dout  in  128  core Dout.
- aes_kvld, aes_dvld, aes_bsy  in  1  core status.

Behaviour:
- Reset values: all outputs 0 except aes_en=1; buffer empty; state IDLE.
- The handshake with the core is registered.
  - aes_krdy and aes_drdy are single-cycle pulses.
  - aes_kin and aes_din are held stable from the pulse until the matching kvld/dvld.
- States: IDLE, KEY, ISSUE, WAIT, DRAIN, FIN.
- IDLE:
  - key_load -> KEY, asserting aes_krdy with aes_kin=key_in in the same transition.
  - Otherwise start with key_ok=1 -> ISSUE; nonce and n_blocks are latched, idx=0, blk_cnt=0.
  - start with key_ok=0 is ignored.
  - key_load and start in the same cycle: key wins; start is dropped.
- KEY: wait for aes_kvld -> set key_ok, go to IDLE.
- ISSUE:
  - If blk_cnt==n_blocks -> DRAIN.
  - Else, if buffer occupancy < 2 and aes_bsy=0: pulse aes_drdy with aes_din={nonce, idx}, then idx++, blk_cnt++, go to WAIT.
  - Else stay in ISSUE.
- WAIT: on aes_dvld, write aes_dout into the buffer and return to ISSUE. At most one block is in flight.
- DRAIN: stay until the buffer is empty, then go to FIN.
- FIN: pulse done for one cycle, then go to IDLE.
- n_blocks=0: ISSUE -> DRAIN -> FIN. done pulses exactly 3 cycles after start.
- Output buffer:
  - 2-entry FIFO, first-word-fall-through.
  - rnd_valid = not empty.
  - A pop occurs on rnd_valid && rnd_ready.
  - Push and pop in the same cycle when full is legal; occupancy is unchanged.
  - rnd_out is stable while rnd_valid=1 and rnd_ready=0.
- idx wraps modulo 2^(128-NONCE_W) with no flag; blk_cnt cannot wrap because it is bounded by n_blocks.
- abort:
  - In ISSUE or DRAIN: flush the buffer and go to FIN.
  - In WAIT: the abort is latched; the in-flight result is discarded on aes_dvld, the buffer is flushed, then go to FIN.
  - In IDLE or KEY: ignored.
- key_load and start are ignored while busy=1.
- Asserting RSTn mid-operation: everything returns to reset values and key_ok=0. The core is reset by the same RSTn.

Test Plan:
- Reset, then key_load with key_in=128'd123 -> one aes_krdy pulse with aes_kin=123; key_ok=1 after aes_kvld; busy=0.
- start, nonce=0, n_blocks=3, rnd_ready=1 -> aes_din sequence 0, 1, 2 (one per aes_drdy). Outputs are AES_123(0), AES_123(1), AES_123(2) in order; blk_cnt=3; done pulses once after the last pop.
- Same run with rnd_ready=0 until both buffer entries are full -> no third aes_drdy while full; rnd_out holds the first block. Releasing rnd_ready drains in order and no blocks are lost.
- start with n_blocks=0 -> done exactly 3 cycles later and no aes_drdy. start before any key_load -> ignored, busy stays 0.
- n_blocks=10, abort during WAIT of block 4 -> that result is discarded, rnd_valid=0, done pulses once, state returns to IDLE. A subsequent run restarts at idx=0.
- RSTn low during WAIT -> all outputs reset and key_ok=0; start after reset is ignored until a new key_load.
